// File: rtl/seq_detector.sv
// Serial pattern detector: flags when the last PAT_W accepted bits equal `pattern`,
// with a saturating match counter and a primed-window indicator.
module seq_detector #(
    parameter int PAT_W   = 4,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [0:0]       state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] win;

    assign win = {hist_q, din};

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        if (clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
            cnt_d   = '0;
        end else if (en) begin
            hist_d = win[PAT_W-2:0];
            if (state_q == ST_FILL) begin
                fill_d = fill_q + 1'b1;
                if (fill_q == FILL_LAST - 1'b1) begin
                    state_d = ST_ARMED;
                end
            end else if (win == pattern) begin
                match_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping: history keeps shifting but is stale until refilled
                if (OVERLAP == 0) begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign armed     = (state_q == ST_ARMED);
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: three configurations driven in parallel and checked
// against a queue-based reference model, constant vector tables and corner sequences.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] pattern = 4'b1101;

    logic       m0, m1, m2, a0, a1, a2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    always #5 clk = ~clk;

    seq_detector #(.PAT_W(4), .OVERLAP(1), .CNT_W(8)) u_ovl (
        .clk(clk), .rst(rst_n), .en(en), .din(din), .clear(clear), .pattern(pattern),
        .match(m0), .armed(a0), .match_cnt(c0));
    seq_detector #(.PAT_W(4), .OVERLAP(0), .CNT_W(8)) u_novl (
        .clk(clk), .rst(rst_n), .en(en), .din(din), .clear(clear), .pattern(pattern),
        .match(m1), .armed(a1), .match_cnt(c1));
    seq_detector #(.PAT_W(4), .OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst_n), .en(en), .din(din), .clear(clear), .pattern(pattern),
        .match(m2), .armed(a2), .match_cnt(c2));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference: count of fresh accepted bits plus the accepted-bit history itself
    int ref_n[3];
    int ref_cnt[3];
    bit ref_m[3];
    bit hq[$];

    typedef struct {
        bit en;
        bit din;
        bit clr;
        bit em;
        bit ea;
        int ec;
    } vec_t;
    vec_t tv[19];

    function automatic int cmax(int k);
        return (k == 2) ? 3 : 255;
    endfunction

    function automatic bit ovl(int k);
        return (k != 1);
    endfunction

    function automatic int dut_m(int k);
        case (k)
            0: return int'(m0);
            1: return int'(m1);
            default: return int'(m2);
        endcase
    endfunction

    function automatic int dut_a(int k);
        case (k)
            0: return int'(a0);
            1: return int'(a1);
            default: return int'(a2);
        endcase
    endfunction

    function automatic int dut_c(int k);
        case (k)
            0: return int'(c0);
            1: return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ref_n[k] = 0;
            ref_cnt[k] = 0;
            ref_m[k] = 1'b0;
        end
        hq.delete();
    endtask

    task automatic model_step(input bit e, input bit d, input bit c);
        logic [3:0] w;
        bit hit;
        if (c) begin
            model_reset();
        end else if (e) begin
            w = '0;
            foreach (hq[i]) w = {w[2:0], hq[i]};
            w = {w[2:0], d};
            for (int k = 0; k < 3; k++) begin
                hit = (ref_n[k] >= 3) && (w == pattern);
                ref_m[k] = hit;
                if (hit && ref_cnt[k] < cmax(k)) ref_cnt[k]++;
                if (hit && !ovl(k)) ref_n[k] = 0;
                else if (ref_n[k] < 3) ref_n[k]++;
            end
            hq.push_back(d);
            if (hq.size() > 3) void'(hq.pop_front());
        end else begin
            for (int k = 0; k < 3; k++) ref_m[k] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s match[%0d]", tag, k), dut_m(k), int'(ref_m[k]));
            check($sformatf("%s armed[%0d]", tag, k), dut_a(k), (ref_n[k] >= 3) ? 1 : 0);
            check($sformatf("%s cnt[%0d]", tag, k), dut_c(k), ref_cnt[k]);
        end
    endtask

    task automatic step(input bit e, input bit d, input bit c, input string tag);
        en = e;
        din = d;
        clear = c;
        model_step(e, d, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        bit s3_m0[7], s3_m1[7], s3_a1[7];
        bit b;

        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tv[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tv[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tv[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tv[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tv[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tv[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tv[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1};

        s3_m0 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        s3_m1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        s3_a1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1};

        // Reset held with random activity on the inputs
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = 1'($urandom);
            din = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("reset");
        end
        en = 1'b0;
        rst_n = 1'b1;

        // Vector table on the overlapping, 8-bit-counter instance
        pattern = 4'b1101;
        for (int i = 0; i < 19; i++) begin
            step(tv[i].en, tv[i].din, tv[i].clr, "tbl");
            check($sformatf("tbl[%0d] match", i), int'(m0), int'(tv[i].em));
            check($sformatf("tbl[%0d] armed", i), int'(a0), int'(tv[i].ea));
            check($sformatf("tbl[%0d] cnt", i), int'(c0), tv[i].ec);
        end

        // Overlap vs non-overlap on 1101101
        step(1'b0, 1'b0, 1'b1, "ovl_clr");
        for (int i = 0; i < 7; i++) begin
            b = (i == 2 || i == 5) ? 1'b0 : 1'b1;
            step(1'b1, b, 1'b0, "ovl");
            check($sformatf("ovl bit%0d match", i), int'(m0), int'(s3_m0[i]));
            check($sformatf("novl bit%0d match", i), int'(m1), int'(s3_m1[i]));
            check($sformatf("novl bit%0d armed", i), int'(a1), int'(s3_a1[i]));
        end
        check("ovl cnt", int'(c0), 2);
        check("novl cnt", int'(c1), 1);

        // Saturation with all-ones pattern, then async reset between edges
        step(1'b0, 1'b0, 1'b1, "sat_clr");
        pattern = 4'b1111;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, "sat");
        check("sat ovl cnt", int'(c0), 5);
        check("sat novl cnt", int'(c1), 2);
        check("sat cnt2", int'(c2), 3);
        en = 1'b1;
        din = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("async_hold");
        rst_n = 1'b1;

        // Randomized traffic with occasional clears and pattern changes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) pattern = 4'($urandom);
            step(($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 39) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
